hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core: resolves RAW hazards by forwarding to D and E, inserts load-use and branch-compare stalls, and sequences a multi-cycle divider with an internal timer FSM. It also arbitrates cache-miss freezes and exception flushes into per-stage stall and flush controls. Sits beside the datapath, fed by the D/E/M/W pipeline registers and the cache and CP0 status lines.

## Interface

- REG_AW, 5, register-index width
- DIV_CYCLES, 32, divider busy cycles (≥1)

- clk  in  1  core clock
- resetn  in  1  asynchronous reset, active low
- rsD, rtD  in  REG_AW  D-stage source registers
- branchD  in  1  D-stage branch/jr needs operands for compare
- rsE, rtE, writeregE  in  REG_AW  E-stage sources and destination
- regwriteE, memtoregE  in  1  E writes regfile / E is a load
- divstartE  in  1  E holds a div/divu
- writeregM  in  REG_AW  M destination
- regwriteM, memtoregM  in  1  M writes regfile / M is a load
- writeregW  in  REG_AW  W destination
- regwriteW  in  1  W writes regfile
- i_stall, d_stall  in  1  icache / dcache miss pending
- except_M  in  1  exception or eret committing in M
- stallF, stallD, stallE, stallM, stallW  out  1  hold stage register
- flushD, flushE, flushM, flushW  out  1  load bubble into stage register
- forwardaD, forwardbD  out  2  D operand select
- forwardaE, forwardbE  out  2  E operand select
- div_busy, div_done  out  1  divider running / result valid this cycle

## Operation

- Forward encoding: 00 regfile, 01 from W, 10 from M. Index 0 never forwards. M beats W. Applies identically to D (branch compare) and E (ALU).
- Load-use: memtoregE & (rtE==rsD | rtE==rtD) → lwstall.
- Branch stall: branchD & ((regwriteE & writeregE∈{rsD,rtD}, writeregE≠0) | (memtoregM & writeregM∈{rsD,rtD}, writeregM≠0)).
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE→BUSY when divstartE & ~d_stall & ~except_M; counter loads DIV_CYCLES−1.
  - BUSY: counter decrements each cycle unless d_stall; at counter==0 → DONE.
  - DONE: div_done=1; → IDLE when ~d_stall (held otherwise). divstartE seen in DONE does not restart.
  - except_M in any state → IDLE next cycle, counter cleared.
- divstall = (IDLE & divstartE) | BUSY.
- Priority, highest first:
  1. except_M & ~d_stall: flushD/E/M=1, all stalls 0.
  2. d_stall: stallF..stallW=1, flushes 0.
  3. divstall: stallF/D/E=1, flushM=1.
  4. lwstall | branch stall: stallF/D=1, flushE=1.
  5. i_stall: stallF=1, flushD=1.
- flushW used only in reset.
- div_busy = BUSY.

## Timing

- Forwarding, stalls, and flushes are combinational in the current cycle's inputs plus FSM state. The only registers are the FSM and counter; counter width is $clog2(DIV_CYCLES+1).
- Reset (resetn low, async):
  - Registers: state IDLE, counter 0.
  - Outputs: all flush outputs 1, all stalls 0, forwards 00, div_busy/div_done 0.
- Divide issued in cycle t with no other events:
  - E stalled t..t+DIV_CYCLES.
  - DONE and div_done at t+DIV_CYCLES+1.
  - Instruction enters M at t+DIV_CYCLES+2.
- Each d_stall cycle during BUSY or DONE extends the sequence by one cycle.
- except_M with d_stall high is deferred: M is frozen and except_M stays asserted until d_stall falls.

## Structure

- Shared package hazard_pkg:
  - FWD_NONE/FWD_W/FWD_M constants.
  - div_state_t enum {IDLE, BUSY, DONE}.
- Sub-module div_timer holds the FSM and counter.
  - Inputs: start, hold, abort.
  - Outputs: busy, done.
- Top level holds the forwarding and priority logic.

## Test plan

- rsE=3, writeregM=3/regwriteM=1, writeregW=3/regwriteW=1 → forwardaE=10. Clear regwriteM → 01. Set rsE=0 → 00.
- memtoregE=1, rtE=5, rsD=5 → stallF=stallD=flushE=1 for exactly one cycle. Same with branchD and memtoregM/writeregM=5 next cycle → one more stall.
- DIV_CYCLES=4, divstartE pulse at t → stallE high t..t+4, div_busy t+1..t+4, div_done at t+5 only, flushM high t..t+4.
- Same divide with d_stall high for 2 cycles mid-BUSY → div_done moves to t+7. All stalls high during the d_stall cycles.
- except_M at t+2 of a divide → state IDLE at t+3, flushD/E/M=1 at t+2, no div_done.
- resetn dropped mid-BUSY → immediate IDLE, flushes 1, div_busy 0. Release, then a new divide completes in the full DIV_CYCLES+1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared hazard-control constants: forward selects and divider states.
// Imported by hazard_ctrl and div_timer.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_timer.sv
// Multi-cycle divider sequencer: IDLE -> BUSY (CYCLES) -> DONE.
// Ports: clk, rst_n, i_start, i_hold, i_abort -> o_busy, o_done.
module div_timer
  import hazard_pkg::*;
#(
  parameter int CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_hold,
  input  logic i_abort,
  output logic o_busy,
  output logic o_done
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

  div_state_t    r_state;
  div_state_t    w_state_n;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    if (i_abort) begin
      w_state_n = IDLE;
      w_cnt_n   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_start && !i_hold) begin
            w_state_n = BUSY;
            w_cnt_n   = LOAD;
          end
        end
        BUSY: begin
          if (!i_hold) begin
            if (r_cnt == '0) begin
              w_state_n = DONE;
            end else begin
              w_cnt_n = r_cnt - 1'b1;
            end
          end
        end
        DONE: begin
          if (!i_hold) begin
            w_state_n = IDLE;
          end
        end
        default: begin
          w_state_n = IDLE;
          w_cnt_n   = '0;
        end
      endcase
    end
  end

  assign o_busy = (r_state == BUSY);
  assign o_done = (r_state == DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding, load-use/branch/div stalls, freezes, flushes.
// In: D/E/M/W regs, cache misses, except_M. Out: stall*/flush*/forward*/div.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic              divstartE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteW,
  input  logic              i_stall,
  input  logic              d_stall,
  input  logic              except_M,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              stallW,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic [1:0]        forwardaD,
  output logic [1:0]        forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              div_busy,
  output logic              div_done
);

  logic w_busy;
  logic w_done;
  logic w_idle;
  logic w_divstall;
  logic w_lwstall;
  logic w_brE;
  logic w_brM;
  logic w_brstall;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] wm,
    input logic              rm,
    input logic [REG_AW-1:0] ww,
    input logic              rw
  );
    logic [1:0] sel;
    sel = FWD_NONE;
    if (src != '0) begin
      if (rm && (wm == src)) begin
        sel = FWD_M;
      end else if (rw && (ww == src)) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

  div_timer #(
    .CYCLES (DIV_CYCLES)
  ) u_div (
    .clk     (clk),
    .rst_n   (resetn),
    .i_start (divstartE),
    .i_hold  (d_stall),
    .i_abort (except_M),
    .o_busy  (w_busy),
    .o_done  (w_done)
  );

  assign w_idle     = !w_busy && !w_done;
  assign w_divstall = (w_idle && divstartE) || w_busy;

  assign w_lwstall = memtoregE &&
                     ((rtE == rsD) || (rtE == rtD));

  assign w_brE = regwriteE && (writeregE != '0) &&
                 ((writeregE == rsD) || (writeregE == rtD));
  assign w_brM = memtoregM && (writeregM != '0) &&
                 ((writeregM == rsD) || (writeregM == rtD));
  assign w_brstall = branchD && (w_brE || w_brM);

  assign div_busy = w_busy;
  assign div_done = w_done;

  always_comb begin
    forwardaD = FWD_NONE;
    forwardbD = FWD_NONE;
    forwardaE = FWD_NONE;
    forwardbE = FWD_NONE;
    if (resetn) begin
      forwardaD = fwd_sel(rsD, writeregM, regwriteM,
                          writeregW, regwriteW);
      forwardbD = fwd_sel(rtD, writeregM, regwriteM,
                          writeregW, regwriteW);
      forwardaE = fwd_sel(rsE, writeregM, regwriteM,
                          writeregW, regwriteW);
      forwardbE = fwd_sel(rtE, writeregM, regwriteM,
                          writeregW, regwriteW);
    end
  end

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    stallW = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (!resetn) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else if (except_M && !d_stall) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
    end else if (d_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      stallW = 1'b1;
    end else if (w_divstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (w_lwstall || w_brstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else if (i_stall) begin
      stallF = 1'b1;
      flushD = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a behavioural model.
// Directed test-plan scenarios followed by randomized traffic.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int DC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic [AW-1:0] rsD, rtD, rsE, rtE;
  logic [AW-1:0] writeregE, writeregM, writeregW;
  logic          branchD, regwriteE, memtoregE, divstartE;
  logic          regwriteM, memtoregM, regwriteW;
  logic          i_stall, d_stall, except_M;
  logic          stallF, stallD, stallE, stallM, stallW;
  logic          flushD, flushE, flushM, flushW;
  logic [1:0]    forwardaD, forwardbD, forwardaE, forwardbE;
  logic          div_busy, div_done;

  hazard_ctrl #(
    .REG_AW     (AW),
    .DIV_CYCLES (DC)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rsD       (rsD),
    .rtD       (rtD),
    .branchD   (branchD),
    .rsE       (rsE),
    .rtE       (rtE),
    .writeregE (writeregE),
    .regwriteE (regwriteE),
    .memtoregE (memtoregE),
    .divstartE (divstartE),
    .writeregM (writeregM),
    .regwriteM (regwriteM),
    .memtoregM (memtoregM),
    .writeregW (writeregW),
    .regwriteW (regwriteW),
    .i_stall   (i_stall),
    .d_stall   (d_stall),
    .except_M  (except_M),
    .stallF    (stallF),
    .stallD    (stallD),
    .stallE    (stallE),
    .stallM    (stallM),
    .stallW    (stallW),
    .flushD    (flushD),
    .flushE    (flushE),
    .flushM    (flushM),
    .flushW    (flushW),
    .forwardaD (forwardaD),
    .forwardbD (forwardbD),
    .forwardaE (forwardaE),
    .forwardbE (forwardbE),
    .div_busy  (div_busy),
    .div_done  (div_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: cycles of divide work left, and a pending result flag.
  int m_left = 0;
  bit m_done = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] s);
    if (s == 0) return 2'd0;
    if (regwriteM && writeregM == s) return 2'd2;
    if (regwriteW && writeregW == s) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit hits(input logic [AW-1:0] w);
    return (w != 0) && (w == rsD || w == rtD);
  endfunction

  task automatic check_outs();
    logic [4:0] st;
    logic [3:0] fl;
    logic [7:0] fw;
    logic [1:0] dv;
    bit dvs, lw, br;
    st = '0; fl = '0; fw = '0; dv = '0;
    if (!resetn) begin
      fl = 4'b1111;
    end else begin
      fw = {m_fwd(rsD), m_fwd(rtD), m_fwd(rsE), m_fwd(rtE)};
      dv = {m_left > 0, m_done};
      dvs = (m_left > 0) || (m_left == 0 && !m_done && divstartE);
      lw = memtoregE && (rtE == rsD || rtE == rtD);
      br = branchD && ((regwriteE && hits(writeregE)) ||
                       (memtoregM && hits(writeregM)));
      if (except_M && !d_stall) fl = 4'b1110;
      else if (d_stall) st = 5'b11111;
      else if (dvs) begin st = 5'b11100; fl = 4'b0010; end
      else if (lw || br) begin st = 5'b11000; fl = 4'b0100; end
      else if (i_stall) begin st = 5'b10000; fl = 4'b1000; end
    end
    check("stall", {stallF, stallD, stallE, stallM, stallW}, st);
    check("flush", {flushD, flushE, flushM, flushW}, fl);
    check("fwd", {forwardaD, forwardbD, forwardaE, forwardbE}, fw);
    check("div", {div_busy, div_done}, dv);
  endtask

  task automatic model_clk();
    if (!resetn || except_M) begin
      m_left = 0;
      m_done = 1'b0;
    end else if (m_done) begin
      if (!d_stall) m_done = 1'b0;
    end else if (m_left > 0) begin
      if (!d_stall) begin
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end
    end else if (divstartE && !d_stall) begin
      m_left = DC;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outs();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic clr();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    branchD = 0; regwriteE = 0; memtoregE = 0; divstartE = 0;
    regwriteM = 0; memtoregM = 0; regwriteW = 0;
    i_stall = 0; d_stall = 0; except_M = 0;
  endtask

  // Pulse a divide at k=0; optional d_stall window and except_M cycle.
  // Returns the cycle index where div_done is first seen, or -1.
  task automatic div_run(input int ds_at, input int ds_len,
                         input int ex_at, output int lat);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      divstartE = (k == 0);
      d_stall   = (k >= ds_at) && (k < ds_at + ds_len);
      except_M  = (k == ex_at);
      @(negedge clk);
      check_outs();
      if (k == ex_at + 1) check("ex_idle", div_busy, 1'b0);
      if (div_done && lat < 0) lat = k;
      @(posedge clk);
      model_clk();
      #1;
    end
    clr();
  endtask

  int lat;

  initial begin
    clr();
    resetn = 1'b0;
    #1;
    check_outs();
    @(negedge clk);
    check_outs();
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Forwarding priority and zero index.
    rsE = 3; writeregM = 3; regwriteM = 1;
    writeregW = 3; regwriteW = 1;
    @(negedge clk);
    check("fwdaE_M", forwardaE, 2'b10);
    cycle();
    regwriteM = 0;
    @(negedge clk);
    check("fwdaE_W", forwardaE, 2'b01);
    cycle();
    rsE = 0;
    @(negedge clk);
    check("fwdaE_0", forwardaE, 2'b00);
    cycle();
    clr();

    // Load-use, then branch on the load now in M.
    memtoregE = 1; rtE = 5; rsD = 5;
    cycle();
    clr();
    branchD = 1; rsD = 5; memtoregM = 1; writeregM = 5;
    cycle();
    clr();
    cycle();

    div_run(99, 0, 99, lat);
    check("div_lat", lat, DC + 1);
    div_run(2, 2, 99, lat);
    check("div_lat_ds", lat, DC + 3);
    div_run(99, 0, 2, lat);
    check("div_abort", lat, -1);

    // Asynchronous reset in the middle of BUSY.
    divstartE = 1;
    cycle();
    divstartE = 0;
    cycle();
    #2;
    resetn = 1'b0;
    m_left = 0;
    m_done = 1'b0;
    #1;
    check("rst_busy", div_busy, 1'b0);
    check_outs();
    @(negedge clk);
    check_outs();
    resetn = 1'b1;
    @(posedge clk);
    #1;
    div_run(99, 0, 99, lat);
    check("div_lat_rst", lat, DC + 1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rsD = AW'($urandom_range(0, 3));
      rtD = AW'($urandom_range(0, 3));
      rsE = AW'($urandom_range(0, 3));
      rtE = AW'($urandom_range(0, 3));
      writeregE = AW'($urandom_range(0, 3));
      writeregM = AW'($urandom_range(0, 3));
      writeregW = AW'($urandom_range(0, 3));
      branchD   = ($urandom_range(0, 3) == 0);
      regwriteE = $urandom_range(0, 1);
      memtoregE = ($urandom_range(0, 3) == 0);
      divstartE = ($urandom_range(0, 5) == 0);
      regwriteM = $urandom_range(0, 1);
      memtoregM = ($urandom_range(0, 3) == 0);
      regwriteW = $urandom_range(0, 1);
      i_stall   = ($urandom_range(0, 3) == 0);
      d_stall   = ($urandom_range(0, 4) == 0);
      except_M  = ($urandom_range(0, 24) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
